uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clk cycles per serial bit; SHALL be an even value >= 4.
REQ-002 Port: clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 Port: rx  input  1  serial line, 8N1, LSB first, idle high; asynchronous to clk.
REQ-005 Port: data  output  8  last correctly framed byte.
REQ-006 Port: valid  output  1  one-cycle pulse when data is updated.
REQ-007 Port: frame_err  output  1  one-cycle pulse when a frame's stop bit samples 0.
REQ-008 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use; both flops SHALL reset to 1.
REQ-010 The FSM SHALL have exactly the states IDLE, START, DATA, STOP and BREAK.
REQ-011 The bit counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL clear on every state change.
REQ-012 IDLE: rx_s==0 -> START.
REQ-013 START: at count CLKS_PER_BIT/2-1 (mid start bit), rx_s==0 -> DATA with bit index 0; rx_s==1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: at each count CLKS_PER_BIT-1, rx_s SHALL shift into the byte register LSB first; after the 8th sample -> STOP.
REQ-015 STOP: at count CLKS_PER_BIT-1, rx_s==1 SHALL load data from the shift register, pulse valid for one cycle, and go to IDLE.
REQ-016 STOP: at count CLKS_PER_BIT-1, rx_s==0 SHALL pulse frame_err for one cycle, leave data unchanged, and go to BREAK.
REQ-017 BREAK: SHALL stay until rx_s==1, then -> IDLE; no start detection SHALL occur while in BREAK.
REQ-018 valid and frame_err SHALL never be high in the same cycle; each SHALL be high for exactly one cycle per frame.
REQ-019 data SHALL hold its value between valid pulses; the shift register SHALL not be visible on data.
REQ-020 Latency: valid SHALL rise 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clk cycles (+/-1) after the rx falling edge of the start bit.
REQ-021 Back-to-back frames: a start bit that immediately follows a valid stop bit SHALL be detected in IDLE without a lost frame.
REQ-022 No handshake SHALL be provided: a consumer that misses the valid pulse loses the byte, and no overrun indication SHALL exist.

Reset
REQ-023 On rst==0, asynchronously: state = IDLE, counters = 0, shift register = 0, data = 8'h00, valid = 0, frame_err = 0, busy = 0, synchronizer flops = 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err pulse.
REQ-025 After reset release, the next falling edge on rx SHALL be treated as a fresh start bit.

Verification (CLKS_PER_BIT=16, 160 clk cycles per frame)
REQ-026 Send frame 0x55 -> exactly one valid pulse, data==8'h55, frame_err never high, busy low after the pulse.
REQ-027 Send 0xA3, 0x00, 0xFF back-to-back with no idle gap -> three valid pulses, data sequence A3, 00, FF.
REQ-028 Hold rx low for 4 cycles from idle, then return high -> busy high briefly, returns to IDLE, no valid and no frame_err.
REQ-029 Send 0x3C with stop bit = 0, then keep rx low for 40 cycles -> one frame_err pulse, data unchanged, busy high until rx returns to 1.
REQ-030 Assert rst=0 during bit 4 of a 0x81 frame, release it, then send 0x81 -> no pulse for the aborted frame, data==00 while in reset, then data==81 with one valid pulse.
REQ-031 Over every scenario, check the valid timing against REQ-020 and that valid and frame_err are mutually exclusive.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_rx.
//   rx        : serial line into the receiver (8N1, LSB first, idle high)
//   data      : last correctly framed byte
//   valid     : one-cycle pulse when data is updated
//   frame_err : one-cycle pulse when a stop bit samples 0
//   busy      : receiver is inside a frame or waiting out a break
// The slave modport is the receiver; the master modport drives the line and observes results.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport slave (
        input  rx,
        output data,
        output valid,
        output frame_err,
        output busy
    );

    modport master (
        output rx,
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a two-flop input synchronizer, mid-bit sampling,
// start-glitch rejection and break handling after a framing error.
//   clk : system clock, all state updates on its rising edge
//   rst : asynchronous active-low reset
//   bus : uart_rx_if.slave (rx in; data, valid, frame_err, busy out)
// CLKS_PER_BIT must be even and >= 4.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            frame_err_q, frame_err_d;
    logic            rx_meta_q;
    logic            rx_s;

    // Synchronizer flops reset to the idle line level so reset release never looks like a start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s      <= rx_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CntW'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        // Every transition clears the counter so each state times from its own entry.
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = StData;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                // Entered at mid start bit, so a full bit period later is mid data bit.
                if (cnt_q == CntLast) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end
            end
            StBreak: begin
                // A held-low line must not be mistaken for a new start bit.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int unsigned Cpb = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    // Observations collected at the falling clock edge.
    int   valid_cnt;
    int   fe_cnt;
    int   both_cnt;
    int   vcyc_q[$];
    logic [7:0] vdata_q[$];
    int   start_q[$];

    uart_rx_if u_if ();

    uart_rx #(
        .CLKS_PER_BIT(Cpb)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (u_if.valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            vcyc_q.push_back(cyc);
            vdata_q.push_back(u_if.data);
        end
        if (u_if.frame_err === 1'b1) fe_cnt = fe_cnt + 1;
        if (u_if.valid === 1'b1 && u_if.frame_err === 1'b1) both_cnt = both_cnt + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        vcyc_q.delete();
        vdata_q.delete();
        start_q.delete();
    endtask

    // Drives one whole frame starting at the current falling edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        start_q.push_back(cyc);
        u_if.rx = 1'b0;
        wait_cycles(Cpb);
        for (int i = 0; i < 8; i++) begin
            u_if.rx = b[i];
            wait_cycles(Cpb);
        end
        u_if.rx = stop_bit;
        wait_cycles(Cpb);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        u_if.rx = 1'b1;
        wait_cycles(3);
        #1;
        checks++; if (u_if.data !== 8'h00) begin errors++;
            $display("FAIL reset_data: got %h want 00", u_if.data); end
        checks++; if (u_if.valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b want 0", u_if.valid); end
        checks++; if (u_if.frame_err !== 1'b0) begin errors++;
            $display("FAIL reset_frame_err: got %b want 0", u_if.frame_err); end
        checks++; if (u_if.busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b want 0", u_if.busy); end
        @(negedge clk);
        rst = 1'b1;
        wait_cycles(4);
    endtask

    task automatic test_single();
        int v0, f0, lat;
        clear_obs();
        v0 = valid_cnt; f0 = fe_cnt;
        send_frame(8'h55, 1'b1);
        wait_cycles(10);
        #1;
        checks++; if (valid_cnt - v0 !== 1) begin errors++;
            $display("FAIL single_valid_count: got %0d want 1", valid_cnt - v0); end
        checks++; if (u_if.data !== 8'h55) begin errors++;
            $display("FAIL single_data: got %h want 55", u_if.data); end
        checks++; if (fe_cnt !== f0) begin errors++;
            $display("FAIL single_frame_err: got %0d pulses want 0", fe_cnt - f0); end
        checks++; if (u_if.busy !== 1'b0) begin errors++;
            $display("FAIL single_busy: got %b want 0", u_if.busy); end
        lat = (vcyc_q.size() > 0) ? vcyc_q[0] - start_q[0] : -1;
        checks++; if (lat < 153 || lat > 155) begin errors++;
            $display("FAIL single_latency: got %0d want 153..155", lat); end
    endtask

    task automatic test_back_to_back();
        int v0, lat;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'hA3; exp_b[1] = 8'h00; exp_b[2] = 8'hFF;
        clear_obs();
        v0 = valid_cnt;
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
        wait_cycles(10);
        #1;
        checks++; if (valid_cnt - v0 !== 3) begin errors++;
            $display("FAIL b2b_valid_count: got %0d want 3", valid_cnt - v0); end
        for (int i = 0; i < 3; i++) begin
            if (i < vdata_q.size()) begin
                checks++; if (vdata_q[i] !== exp_b[i]) begin errors++;
                    $display("FAIL b2b_data%0d: got %h want %h", i, vdata_q[i], exp_b[i]); end
                lat = vcyc_q[i] - start_q[i];
                checks++; if (lat < 153 || lat > 155) begin errors++;
                    $display("FAIL b2b_latency%0d: got %0d want 153..155", i, lat); end
            end
        end
        checks++; if (both_cnt !== 0) begin errors++;
            $display("FAIL b2b_exclusive: got %0d overlaps want 0", both_cnt); end
    endtask

    task automatic test_glitch();
        int v0, f0;
        logic saw_busy;
        v0 = valid_cnt; f0 = fe_cnt;
        saw_busy = 1'b0;
        u_if.rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (u_if.busy === 1'b1) saw_busy = 1'b1;
        end
        u_if.rx = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (u_if.busy === 1'b1) saw_busy = 1'b1;
        end
        wait_cycles(20);
        #1;
        checks++; if (saw_busy !== 1'b1) begin errors++;
            $display("FAIL glitch_busy_seen: got %b want 1", saw_busy); end
        checks++; if (u_if.busy !== 1'b0) begin errors++;
            $display("FAIL glitch_busy_end: got %b want 0", u_if.busy); end
        checks++; if (valid_cnt !== v0) begin errors++;
            $display("FAIL glitch_valid: got %0d pulses want 0", valid_cnt - v0); end
        checks++; if (fe_cnt !== f0) begin errors++;
            $display("FAIL glitch_frame_err: got %0d pulses want 0", fe_cnt - f0); end
    endtask

    task automatic test_frame_err();
        int v0, f0;
        v0 = valid_cnt; f0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        wait_cycles(40);
        #1;
        checks++; if (fe_cnt - f0 !== 1) begin errors++;
            $display("FAIL ferr_count: got %0d want 1", fe_cnt - f0); end
        checks++; if (valid_cnt !== v0) begin errors++;
            $display("FAIL ferr_valid: got %0d pulses want 0", valid_cnt - v0); end
        checks++; if (u_if.data !== 8'hFF) begin errors++;
            $display("FAIL ferr_data_held: got %h want ff", u_if.data); end
        checks++; if (u_if.busy !== 1'b1) begin errors++;
            $display("FAIL ferr_busy_in_break: got %b want 1", u_if.busy); end
        @(negedge clk);
        u_if.rx = 1'b1;
        wait_cycles(6);
        #1;
        checks++; if (u_if.busy !== 1'b0) begin errors++;
            $display("FAIL ferr_busy_after: got %b want 0", u_if.busy); end
        checks++; if (fe_cnt - f0 !== 1) begin errors++;
            $display("FAIL ferr_single_pulse: got %0d want 1", fe_cnt - f0); end
    endtask

    task automatic test_reset_abort();
        int v0, f0, lat;
        logic [7:0] b;
        b = 8'h81;
        clear_obs();
        v0 = valid_cnt; f0 = fe_cnt;
        u_if.rx = 1'b0;
        wait_cycles(Cpb);
        for (int i = 0; i < 4; i++) begin
            u_if.rx = b[i];
            wait_cycles(Cpb);
        end
        u_if.rx = b[4];
        wait_cycles(Cpb / 2);
        rst = 1'b0;
        #1;
        checks++; if (u_if.data !== 8'h00) begin errors++;
            $display("FAIL abort_data_in_reset: got %h want 00", u_if.data); end
        checks++; if (u_if.busy !== 1'b0) begin errors++;
            $display("FAIL abort_busy_in_reset: got %b want 0", u_if.busy); end
        u_if.rx = 1'b1;
        wait_cycles(5);
        rst = 1'b1;
        wait_cycles(Cpb * 6);
        #1;
        checks++; if (valid_cnt !== v0 || fe_cnt !== f0) begin errors++;
            $display("FAIL abort_no_pulse: got valid %0d ferr %0d want 0 0",
                     valid_cnt - v0, fe_cnt - f0); end
        @(negedge clk);
        send_frame(8'h81, 1'b1);
        wait_cycles(10);
        #1;
        checks++; if (valid_cnt - v0 !== 1) begin errors++;
            $display("FAIL abort_resend_count: got %0d want 1", valid_cnt - v0); end
        checks++; if (u_if.data !== 8'h81) begin errors++;
            $display("FAIL abort_resend_data: got %h want 81", u_if.data); end
        lat = (vcyc_q.size() > 0) ? vcyc_q[0] - start_q[0] : -1;
        checks++; if (lat < 153 || lat > 155) begin errors++;
            $display("FAIL abort_latency: got %0d want 153..155", lat); end
        checks++; if (both_cnt !== 0) begin errors++;
            $display("FAIL final_exclusive: got %0d overlaps want 0", both_cnt); end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        valid_cnt = 0; fe_cnt = 0; both_cnt = 0;
        rst = 1'b0;
        u_if.rx = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
